instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 133 +++++++++++++
 tb/tb_instr_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit words and writes them to sequential
// instruction-memory addresses within a start/stop load session.
//
// state | meaning
// IDLE  | no session; start arms a new one at BASE_ADDR
// RUN   | accepting field bundles and issuing writes
// DRAIN | stop seen with a word held; finish that write, then leave
// FULL  | last address written; only start reopens a session
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [10:0]           opcode,
  input  logic [4:0]            rm,
  input  logic [4:0]            rn,
  input  logic [4:0]            rd,
  input  logic [5:0]            shamt,
  input  logic [25:0]           imm,
  input  logic                  mem_stall,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [`INSTR_LEN-1:0] wr_data,
  output logic                  err,
  output logic                  full,
  output logic [ADDR_W:0]       count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FULL} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  state_t                  state;
  logic [ADDR_W-1:0]       next_addr;
  logic [`INSTR_LEN-1:0]   enc;
  logic                    legal;
  logic                    xfer;
  logic                    done;
  logic                    held_after;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (fmt)
      3'd0:    enc = {opcode, rm, shamt, rn, rd};
      3'd1:    enc = {opcode[10:1], imm[11:0], rn, rd};
      3'd2:    enc = {opcode, imm[8:0], imm[10:9], rn, rd};
      3'd3:    enc = {opcode[10:5], imm};
      3'd4:    enc = {opcode[10:3], imm[18:0], rd};
      3'd5:    enc = {opcode[10:2], imm[17:16], imm[15:0], rd};
      default: legal = 1'b0;
    endcase
  end

  // A word held for the last address blocks intake so the address never wraps.
  assign in_ready   = (state == RUN) &&
                      !(wr_en && (mem_stall || wr_addr == LAST_ADDR));
  assign xfer       = in_valid && in_ready;
  assign done       = wr_en && !mem_stall;
  assign held_after = (xfer && legal) || (wr_en && mem_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      next_addr <= BASE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
      full      <= 1'b0;
      count     <= '0;
    end else begin
      err <= xfer && !legal;

      if (xfer && legal) begin
        wr_en   <= 1'b1;
        wr_addr <= next_addr;
        wr_data <= enc;
        if (next_addr != LAST_ADDR)
          next_addr <= next_addr + ADDR_ONE;
      end else if (done) begin
        wr_en <= 1'b0;
      end

      if (done)
        count <= count + CNT_ONE;

      case (state)
        IDLE, FULL: begin
          if (start) begin
            state     <= RUN;
            next_addr <= BASE;
            count     <= '0;
            full      <= 1'b0;
          end
        end
        RUN: begin
          if (done && wr_addr == LAST_ADDR) begin
            state <= FULL;
            full  <= 1'b1;
          end else if (stop) begin
            state <= held_after ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (done) begin
            if (wr_addr == LAST_ADDR) begin
              state <= FULL;
              full  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, streaming, stall, illegal
// format, stop/drain, async reset mid-write, and a 2-bit-address full session.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [10:0] opcode;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [5:0]  shamt;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, in_valid, mem_stall;
  logic [2:0]  fmt;
  logic [10:0] opcode;
  logic [4:0]  rm, rn, rd;
  logic [5:0]  shamt;
  logic [25:0] imm;

  logic        in_ready, wr_en, err, full;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  count;

  logic        s_in_ready, s_wr_en, s_err, s_full;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_count;

  int total  = 0;
  int passed = 0;
  vec_t tbl[9];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rm(rm), .rn(rn), .rd(rd), .shamt(shamt), .imm(imm),
    .mem_stall(mem_stall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err), .full(full), .count(count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(s_in_ready), .fmt(fmt), .opcode(opcode),
    .rm(rm), .rn(rn), .rd(rd), .shamt(shamt), .imm(imm),
    .mem_stall(mem_stall), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .err(s_err), .full(s_full), .count(s_count)
  );

  function automatic vec_t mk(input logic [2:0] f, input logic [10:0] op,
                              input logic [4:0] m, input logic [4:0] n,
                              input logic [4:0] d, input logic [5:0] sh,
                              input logic [25:0] im, input logic [31:0] e);
    vec_t v;
    v.fmt = f; v.opcode = op; v.rm = m; v.rn = n; v.rd = d;
    v.shamt = sh; v.imm = im; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    fmt = v.fmt; opcode = v.opcode; rm = v.rm; rn = v.rn; rd = v.rd;
    shamt = v.shamt; imm = v.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // fmt, opcode, rm, rn, rd, shamt, imm, expected word
    tbl[0] = mk(3'd0, 11'h458, 5'd2,  5'd1,  5'd3, 6'd0,  26'h0,       32'h8B020023);
    tbl[1] = mk(3'd2, 11'h7C2, 5'd0,  5'd1,  5'd2, 6'd0,  26'd8,       32'hF8408022);
    tbl[2] = mk(3'd3, 11'h0A0, 5'd0,  5'd0,  5'd0, 6'd0,  26'd3,       32'h14000003);
    tbl[3] = mk(3'd4, 11'h5A0, 5'd0,  5'd0,  5'd5, 6'd0,  26'd4,       32'hB4000085);
    tbl[4] = mk(3'd1, 11'h488, 5'd31, 5'd4,  5'd7, 6'd63, 26'h3FFF123, 32'h91048C87);
    tbl[5] = mk(3'd5, 11'h694, 5'd31, 5'd31, 5'd9, 6'd63, 26'h3C1BEEF, 32'hD2B7DDE9);
    tbl[6] = mk(3'd2, 11'h7C0, 5'd0,  5'd31, 5'd0, 6'd0,  26'h1007FF,  32'hF81FFFE0);
    tbl[7] = mk(3'd4, 11'h5A8, 5'd0,  5'd0,  5'd1, 6'd0,  26'h3FFFFFF, 32'hB5FFFFE1);
    tbl[8] = mk(3'd0, 11'h69B, 5'd0,  5'd2,  5'd3, 6'd5,  26'h0,       32'hD3601443);

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; mem_stall = 1'b0;
    apply(tbl[0]);
    #2;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_err", err, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);
    #10 rst_n = 1'b1;
    step();

    // No session armed: bundle must not be taken
    in_valid = 1'b1;
    #1 check("idle_in_ready", in_ready, 0);
    step();
    check("idle_no_write", wr_en, 0);
    in_valid = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      in_valid = 1'b1;
      step();
      check($sformatf("tbl%0d_wr_en", i), wr_en, 1);
      check($sformatf("tbl%0d_wr_addr", i), wr_addr, i);
      check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].exp);
    end
    in_valid = 1'b0;
    step();
    check("stream_count", count, 9);
    check("stream_wr_en_drop", wr_en, 0);

    // Stall for three cycles with a second word waiting
    apply(tbl[0]); in_valid = 1'b1;
    step();
    check("stall_first_addr", wr_addr, 9);
    apply(tbl[1]); mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("stall%0d_in_ready", k), in_ready, 0);
      step();
      check($sformatf("stall%0d_wr_en", k), wr_en, 1);
      check($sformatf("stall%0d_wr_addr", k), wr_addr, 9);
      check($sformatf("stall%0d_wr_data", k), wr_data, tbl[0].exp);
    end
    mem_stall = 1'b0;
    #1 check("unstall_in_ready", in_ready, 1);
    step();
    check("unstall_wr_addr", wr_addr, 10);
    check("unstall_wr_data", wr_data, tbl[1].exp);
    check("unstall_count", count, 10);
    in_valid = 1'b0;
    step();

    // Illegal format, then a legal word at the unchanged address
    apply(tbl[2]); fmt = 3'd7; in_valid = 1'b1;
    step();
    check("illegal_err", err, 1);
    check("illegal_no_wr", wr_en, 0);
    apply(tbl[3]);
    step();
    check("after_illegal_err", err, 0);
    check("after_illegal_wr_en", wr_en, 1);
    check("after_illegal_addr", wr_addr, 11);
    check("after_illegal_data", wr_data, tbl[3].exp);

    // Stop coinciding with a transfer: word is accepted then drained
    stop = 1'b1; apply(tbl[4]);
    step();
    stop = 1'b0;
    check("stop_xfer_addr", wr_addr, 12);
    check("stop_xfer_data", wr_data, tbl[4].exp);
    check("stop_xfer_count", count, 12);
    apply(tbl[5]); mem_stall = 1'b1;
    #1 check("drain_in_ready", in_ready, 0);
    step();
    check("drain_hold_wr_en", wr_en, 1);
    check("drain_hold_addr", wr_addr, 12);
    mem_stall = 1'b0;
    step();
    check("drain_done_wr_en", wr_en, 0);
    check("drain_done_count", count, 13);
    check("drain_idle_ready", in_ready, 0);
    step();
    check("idle_after_drain", wr_en, 0);

    // Async reset while a stalled write is held
    in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    apply(tbl[6]); in_valid = 1'b1;
    step();
    in_valid = 1'b0; mem_stall = 1'b1;
    step();
    check("pre_rst_wr_en", wr_en, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", wr_en, 0);
    check("async_rst_count", count, 0);
    #2 rst_n = 1'b1;
    mem_stall = 1'b0; in_valid = 1'b1;
    step(); step();
    check("post_rst_wr_en", wr_en, 0);
    check("post_rst_in_ready", in_ready, 0);

    // Two-bit address instance: four writes then full
    in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply(tbl[k]);
      step();
      check($sformatf("small%0d_wr_en", k), s_wr_en, 1);
      check($sformatf("small%0d_addr", k), s_wr_addr, k);
      check($sformatf("small%0d_data", k), s_wr_data, tbl[k].exp);
    end
    apply(tbl[4]);
    #1 check("small_last_ready", s_in_ready, 0);
    step();
    check("small_full", s_full, 1);
    check("small_count", s_count, 4);
    check("small_wr_en_off", s_wr_en, 0);
    check("small_full_ready", s_in_ready, 0);
    step();
    check("small_fifth_rejected", s_wr_en, 0);
    in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("small_restart_full", s_full, 0);
    check("small_restart_count", s_count, 0);
    apply(tbl[5]); in_valid = 1'b1;
    step();
    check("small_restart_addr", s_wr_addr, 0);
    check("small_restart_wr_en", s_wr_en, 1);
    check("small_restart_data", s_wr_data, tbl[5].exp);
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
